loop_counter_nested: RTL and testbench

Parametrised N-level nested loop counter for MFCC sequencing: frame, filter-bank bin, coefficient and similar index loops. Each level has its own runtime terminal value. An inner level's terminal count carries into the next outer level. The block signals the end of a full sequence and can either wrap around or halt (one-shot). It replaces the single fixed-width loop counters in the datapath controllers.

---
 rtl/loop_counter_nested_if.sv | 27 ++
 rtl/loop_counter_nested.sv | 91 +++++++++
 tb/tb_loop_counter_nested.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/loop_counter_nested_if.sv
// Bus bundle for the nested loop counter.
// The controller (master) drives the step controls and the per-level limits.
// The counter (slave) returns the counts, terminal flags and the sequence pulses.
interface loop_counter_nested_if #(
    parameter int LEVELS = 3,
    parameter int WIDTH  = 7
);
    logic                      clr;
    logic                      en;
    logic                      mode;
    logic [LEVELS*WIDTH-1:0]   limit;
    logic [LEVELS*WIDTH-1:0]   count;
    logic [LEVELS-1:0]         last;
    logic [LEVELS-1:0]         wrap;
    logic                      done;
    logic                      halted;

    modport master (
        output clr, en, mode, limit,
        input  count, last, wrap, done, halted
    );

    modport slave (
        input  clr, en, mode, limit,
        output count, last, wrap, done, halted
    );
endinterface

// File: rtl/loop_counter_nested.sv
// N-level nested loop counter with per-level runtime limits.
// Level 0 is innermost, and each level carries into the next outer level on its
// terminal count. A full sequence either wraps every level to zero or, in
// one-shot mode, freezes at the terminal values until a clear.
module loop_counter_nested #(
    parameter int LEVELS = 3,
    parameter int WIDTH  = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    loop_counter_nested_if.slave  bus
);

    typedef enum logic {
        RUNNING = 1'b0,
        HALTED  = 1'b1
    } run_state_t;

    run_state_t                     state_q, state_d;
    logic [LEVELS-1:0][WIDTH-1:0]   count_q, count_d;
    logic [LEVELS-1:0]              wrap_q, wrap_d;
    logic                           done_q, done_d;
    logic [LEVELS-1:0]              last_vec;
    logic [LEVELS-1:0]              carry;
    logic                           chain;
    logic                           step;
    logic                           complete;

    // Terminal flags come straight from the live limits, so a limit change is seen at once
    always_comb begin
        last_vec = '0;
        carry    = '0;
        step     = bus.en & ~bus.clr & (state_q == RUNNING);
        chain    = step;
        for (int i = 0; i < LEVELS; i++) begin
            last_vec[i] = (count_q[i] >= bus.limit[i*WIDTH +: WIDTH]);
            carry[i]    = chain;
            chain       = chain & last_vec[i];
        end
        complete = step & (&last_vec);
    end

    // Next counts, pulses and run state; clear wins, one-shot completion freezes the counts
    always_comb begin
        count_d = count_q;
        wrap_d  = '0;
        done_d  = 1'b0;
        state_d = state_q;
        if (bus.clr) begin
            count_d = '0;
            state_d = RUNNING;
        end else if (complete && bus.mode) begin
            done_d  = 1'b1;
            state_d = HALTED;
        end else begin
            done_d = complete;
            for (int i = 0; i < LEVELS; i++) begin
                if (carry[i]) begin
                    if (last_vec[i]) begin
                        count_d[i] = '0;
                        wrap_d[i]  = 1'b1;
                    end else begin
                        count_d[i] = count_q[i] + WIDTH'(1);
                    end
                end
            end
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            wrap_q  <= '0;
            done_q  <= 1'b0;
            state_q <= RUNNING;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
            state_q <= state_d;
        end
    end

    assign bus.count  = count_q;
    assign bus.last   = last_vec;
    assign bus.wrap   = wrap_q;
    assign bus.done   = done_q;
    assign bus.halted = (state_q == HALTED);

endmodule

// File: tb/tb_loop_counter_nested.sv
// Directed testbench for loop_counter_nested with LEVELS=3, WIDTH=7.
// Each scenario task drives its stimulus and checks outputs against hand-derived values.
module tb_loop_counter_nested;

    localparam int LEVELS = 3;
    localparam int WIDTH  = 7;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    loop_counter_nested_if #(.LEVELS(LEVELS), .WIDTH(WIDTH)) bus ();

    loop_counter_nested #(.LEVELS(LEVELS), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack three level values into the flat count/limit layout
    function automatic logic [20:0] pk(input int a, input int b, input int c);
        logic [6:0] a7, b7, c7;
        a7 = 7'(a);
        b7 = 7'(b);
        c7 = 7'(c);
        return {c7, b7, a7};
    endfunction

    // Expected counts for limits (2,1,3) after s steps from zero
    function automatic logic [20:0] model_count(input int s);
        int n;
        n = s % 24;
        return pk(n % 3, (n / 3) % 2, n / 6);
    endfunction

    // Expected wrap pulses after the s-th step (s >= 1) for limits (2,1,3)
    function automatic logic [2:0] model_wrap(input int s);
        return {(s % 24) == 0, (s % 6) == 0, (s % 3) == 0};
    endfunction

    // Advance one clock and settle just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock with clr asserted
    task automatic applyStimulus_clear();
        bus.clr = 1'b1;
        bus.en  = 1'b0;
        tick();
        bus.clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.clr   = 1'b0;
        bus.en    = 1'b0;
        bus.mode  = 1'b0;
        bus.limit = pk(2, 1, 3);
        tick();
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (bus.count !== 21'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_count got %h want %h", bus.count, 21'd0);
        end
        n_cmp++;
        if (bus.wrap !== 3'b000 || bus.done !== 1'b0 || bus.halted !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_pulses got wrap=%b done=%b halted=%b want 000/0/0",
                     bus.wrap, bus.done, bus.halted);
        end
        n_cmp++;
        if (bus.last !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL reset_last got %b want 000", bus.last);
        end
    endtask

    task automatic test_wrap_mode();
        int done_seen;
        done_seen = 0;
        bus.mode = 1'b0;
        bus.en   = 1'b1;
        for (int s = 1; s <= 24; s++) begin
            tick();
            if (bus.done === 1'b1) done_seen++;
            n_cmp++;
            if (bus.count !== model_count(s)) begin
                n_fail++;
                $display("[TB] FAIL wrap_count step %0d got %h want %h", s, bus.count, model_count(s));
            end
            n_cmp++;
            if (bus.wrap !== model_wrap(s)) begin
                n_fail++;
                $display("[TB] FAIL wrap_pulse step %0d got %b want %b", s, bus.wrap, model_wrap(s));
            end
        end
        bus.en = 1'b0;
        n_cmp++;
        if (done_seen !== 1) begin
            n_fail++;
            $display("[TB] FAIL wrap_done_once got %0d want 1", done_seen);
        end
        tick();
        n_cmp++;
        if (bus.done !== 1'b0 || bus.wrap !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL wrap_idle got done=%b wrap=%b want 0/000", bus.done, bus.wrap);
        end
    endtask

    task automatic test_one_shot();
        int done_seen;
        done_seen = 0;
        applyStimulus_clear();
        bus.mode = 1'b1;
        bus.en   = 1'b1;
        for (int s = 1; s <= 30; s++) begin
            tick();
            if (bus.done === 1'b1) done_seen++;
            n_cmp++;
            if (bus.count !== ((s >= 24) ? pk(2, 1, 3) : model_count(s))) begin
                n_fail++;
                $display("[TB] FAIL oneshot_count step %0d got %h", s, bus.count);
            end
            if (s >= 24) begin
                n_cmp++;
                if (bus.wrap !== 3'b000 || bus.halted !== 1'b1 || bus.done !== (s == 24)) begin
                    n_fail++;
                    $display("[TB] FAIL oneshot_flags step %0d got wrap=%b halted=%b done=%b",
                             s, bus.wrap, bus.halted, bus.done);
                end
            end else begin
                n_cmp++;
                if (bus.halted !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL oneshot_early_halt step %0d got %b want 0", s, bus.halted);
                end
            end
        end
        n_cmp++;
        if (done_seen !== 1) begin
            n_fail++;
            $display("[TB] FAIL oneshot_done_once got %0d want 1", done_seen);
        end
        applyStimulus_clear();
        n_cmp++;
        if (bus.count !== 21'd0 || bus.halted !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL oneshot_clear got count=%h halted=%b want 0/0", bus.count, bus.halted);
        end
        bus.mode = 1'b0;
    endtask

    task automatic test_gapped();
        int s;
        applyStimulus_clear();
        bus.mode = 1'b0;
        for (int k = 1; k <= 48; k++) begin
            bus.en = ((k % 2) == 0);
            tick();
            s = k / 2;
            n_cmp++;
            if (bus.count !== model_count(s)) begin
                n_fail++;
                $display("[TB] FAIL gap_count clock %0d got %h want %h", k, bus.count, model_count(s));
            end
            n_cmp++;
            if (bus.wrap !== (bus.en ? model_wrap(s) : 3'b000) ||
                bus.done !== (bus.en && s == 24)) begin
                n_fail++;
                $display("[TB] FAIL gap_pulses clock %0d got wrap=%b done=%b", k, bus.wrap, bus.done);
            end
        end
        bus.en = 1'b0;
    endtask

    task automatic test_clr_priority();
        applyStimulus_clear();
        bus.en = 1'b1;
        for (int s = 1; s <= 16; s++) tick();
        n_cmp++;
        if (bus.count !== pk(1, 1, 2)) begin
            n_fail++;
            $display("[TB] FAIL clr_setup got %h want %h", bus.count, pk(1, 1, 2));
        end
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        bus.en  = 1'b0;
        n_cmp++;
        if (bus.count !== 21'd0 || bus.done !== 1'b0 || bus.wrap !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL clr_with_en got count=%h done=%b wrap=%b want 0", bus.count, bus.done, bus.wrap);
        end
    endtask

    task automatic test_limit_change();
        bus.limit = pk(7, 1, 1);
        applyStimulus_clear();
        bus.en = 1'b1;
        for (int s = 1; s <= 5; s++) tick();
        bus.en = 1'b0;
        n_cmp++;
        if (bus.count !== pk(5, 0, 0)) begin
            n_fail++;
            $display("[TB] FAIL limchg_setup got %h want %h", bus.count, pk(5, 0, 0));
        end
        bus.limit = pk(3, 1, 1);
        #1;
        n_cmp++;
        if (bus.last !== 3'b001) begin
            n_fail++;
            $display("[TB] FAIL limchg_last got %b want 001", bus.last);
        end
        bus.en = 1'b1;
        tick();
        bus.en = 1'b0;
        n_cmp++;
        if (bus.count !== pk(0, 1, 0) || bus.wrap !== 3'b001 || bus.done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL limchg_step got count=%h wrap=%b done=%b want %h/001/0",
                     bus.count, bus.wrap, bus.done, pk(0, 1, 0));
        end
    endtask

    task automatic test_boundary_and_async_reset();
        bus.limit = pk(127, 0, 0);
        bus.mode  = 1'b0;
        applyStimulus_clear();
        n_cmp++;
        if (bus.last !== 3'b110) begin
            n_fail++;
            $display("[TB] FAIL bound_last0 got %b want 110", bus.last);
        end
        bus.en = 1'b1;
        for (int s = 1; s <= 126; s++) tick();
        n_cmp++;
        if (bus.count !== pk(126, 0, 0) || bus.done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL bound_126 got count=%h done=%b", bus.count, bus.done);
        end
        tick();
        n_cmp++;
        if (bus.count !== pk(127, 0, 0) || bus.last !== 3'b111 || bus.done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL bound_127 got count=%h last=%b done=%b", bus.count, bus.last, bus.done);
        end
        tick();
        n_cmp++;
        if (bus.count !== 21'd0 || bus.done !== 1'b1 || bus.wrap !== 3'b111) begin
            n_fail++;
            $display("[TB] FAIL bound_wrap got count=%h done=%b wrap=%b want 0/1/111",
                     bus.count, bus.done, bus.wrap);
        end
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.count !== 21'd0 || bus.done !== 1'b0 || bus.wrap !== 3'b000 ||
            bus.halted !== 1'b0 || bus.last !== 3'b110) begin
            n_fail++;
            $display("[TB] FAIL async_reset got count=%h done=%b wrap=%b halted=%b last=%b",
                     bus.count, bus.done, bus.wrap, bus.halted, bus.last);
        end
        bus.en = 1'b0;
        rst_n  = 1'b1;
        tick();
    endtask

    // Run all scenarios in order and report
    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_wrap_mode();
        test_one_shot();
        test_gapped();
        test_clr_priority();
        test_limit_change();
        test_boundary_and_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
